// File: rtl/next_pc_unit.sv
// Next-PC generator for the 12-bit program counter: run/halt sequencing,
// branch-target LUT, stall hold, sticky done and a saturating run-cycle counter.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for start to drop; pc_next = 0, LUT writable
// ST_RUN    | program executing; pc_next chosen by stall/halt/branch/+1
// ST_HALT   | halt opcode seen; pc_next = pc_cur, done = 1, counter frozen
module next_pc_unit #(
  parameter int PC_W      = 12,
  parameter int LUT_IDX_W = 5,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [PC_W-1:0]      pc_cur,
  input  logic                 stall,
  input  logic                 halt_insn,
  input  logic                 br_taken,
  input  logic                 br_rel,
  input  logic [LUT_IDX_W-1:0] br_idx,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
  output logic [PC_W-1:0]      pc_next,
  output logic                 running,
  output logic                 done,
  output logic [CNT_W-1:0]     cycle_cnt
);

  localparam int LUT_N = 1 << LUT_IDX_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [PC_W-1:0] lut_mem [LUT_N];
  logic [PC_W-1:0] lut_rd;

  assign lut_rd  = lut_mem[br_idx];
  assign running = (state == ST_RUN);
  assign done    = (state == ST_HALT);

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_RUN;
        ST_RUN:  if (!stall && halt_insn) state_nxt = ST_HALT;
        ST_HALT: state_nxt = ST_HALT;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Counts every RUN edge, stalled and halting cycles included; sticks at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= '0;
    end else if (start) begin
      cycle_cnt <= '0;
    end else if (state == ST_RUN && cycle_cnt != {CNT_W{1'b1}}) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  // Writes depend only on the current state, so a table can be loaded while start holds IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LUT_N; i++) lut_mem[i] <= '0;
    end else if (state == ST_IDLE && lut_we) begin
      lut_mem[lut_waddr] <= lut_wdata;
    end
  end

  always_comb begin
    pc_next = '0;
    case (state)
      ST_RUN: begin
        if (stall || halt_insn) pc_next = pc_cur;
        else if (br_taken)      pc_next = br_rel ? (pc_cur + lut_rd) : lut_rd;
        else                    pc_next = pc_cur + PC_W'(1);
      end
      ST_HALT: pc_next = pc_cur;
      default: pc_next = '0;
    endcase
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Bench for next_pc_unit: directed vector table, reset/saturation sequences and
// randomized stimulus against a behavioural model with an external PC register.
module tb_next_pc_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [11:0] pc_cur;
  logic        stall;
  logic        halt_insn;
  logic        br_taken;
  logic        br_rel;
  logic [4:0]  br_idx;
  logic        lut_we;
  logic [4:0]  lut_waddr;
  logic [11:0] lut_wdata;
  logic [11:0] pc_next;
  logic        running;
  logic        done;
  logic [15:0] cycle_cnt;

  next_pc_unit #(.PC_W(12), .LUT_IDX_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pc_cur(pc_cur),
    .stall(stall), .halt_insn(halt_insn), .br_taken(br_taken), .br_rel(br_rel),
    .br_idx(br_idx), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc_next(pc_next), .running(running), .done(done), .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: program mode, LUT contents and run count as plain integers.
  typedef enum {M_IDLE, M_RUN, M_HALT} mode_t;
  mode_t m_mode;
  int    m_lut [32];
  int    m_cnt;

  task m_reset();
    m_mode = M_IDLE;
    m_cnt  = 0;
    for (int i = 0; i < 32; i++) m_lut[i] = 0;
  endtask

  function automatic int m_pc_next(input int pc);
    int off;
    if (m_mode == M_IDLE) return 0;
    if (m_mode == M_HALT) return pc;
    if (stall || halt_insn) return pc;
    if (br_taken) begin
      if (!br_rel) return m_lut[br_idx];
      off = (m_lut[br_idx] >= 2048) ? m_lut[br_idx] - 4096 : m_lut[br_idx];
      return (((pc + off) % 4096) + 4096) % 4096;
    end
    return (pc + 1) % 4096;
  endfunction

  task m_edge();
    mode_t old;
    old = m_mode;
    if (old == M_IDLE && lut_we) m_lut[lut_waddr] = int'(lut_wdata);
    if (start) begin
      m_mode = M_IDLE;
      m_cnt  = 0;
    end else if (old == M_IDLE) begin
      m_mode = M_RUN;
    end else if (old == M_RUN) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (!stall && halt_insn) m_mode = M_HALT;
    end
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(input logic [11:0] pc, output logic [11:0] pn_seen);
    pc_cur = pc;
    #1;
    pn_seen = pc_next;
    chk("pc_next", 32'(pc_next), 32'(m_pc_next(int'(pc))));
    m_edge();
    @(posedge clk);
    @(negedge clk);
    chk("running", 32'(running), 32'(m_mode == M_RUN));
    chk("done", 32'(done), 32'(m_mode == M_HALT));
    chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
  endtask

  task automatic set_in(input logic st, input logic sl, input logic hl, input logic br,
                        input logic rel, input logic [4:0] idx, input logic we,
                        input logic [4:0] wa, input logic [11:0] wd);
    start = st; stall = sl; halt_insn = hl; br_taken = br; br_rel = rel;
    br_idx = idx; lut_we = we; lut_waddr = wa; lut_wdata = wd;
  endtask

  typedef struct {
    logic        st, sl, hl, br, rel;
    logic [4:0]  idx;
    logic        we;
    logic [4:0]  wa;
    logic [11:0] wd;
    logic [11:0] pc;
    logic [11:0] e_pn;
    logic        e_run, e_done;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic sl, input logic hl, input logic br,
                              input logic rel, input logic [4:0] idx, input logic we,
                              input logic [4:0] wa, input logic [11:0] wd, input logic [11:0] pc,
                              input logic [11:0] pn, input logic run, input logic dn,
                              input logic [15:0] cnt);
    vec_t v;
    v.st = st; v.sl = sl; v.hl = hl; v.br = br; v.rel = rel; v.idx = idx;
    v.we = we; v.wa = wa; v.wd = wd; v.pc = pc;
    v.e_pn = pn; v.e_run = run; v.e_done = dn; v.e_cnt = cnt;
    return v;
  endfunction

  vec_t        vecs[$];
  logic [11:0] pn;
  logic [11:0] pc_reg;

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    pc_cur  = '0;
    reset_n = 1'b0;
    m_reset();
    pc_reg = '0;

    //        st sl hl br rel idx we wa wd       pc       pn      run dn cnt
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 3, 12'h040, 12'h000, 12'h000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 7, 12'hFFE, 12'h000, 12'h000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h001, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h001, 12'h002, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h002, 12'h003, 1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 1, 0, 3, 0, 0, 12'h000, 12'h003, 12'h040, 1, 0, 4));
    vecs.push_back(mk(0, 0, 0, 1, 1, 7, 0, 0, 12'h000, 12'h010, 12'h00E, 1, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'hFFF, 12'h000, 1, 0, 6));
    vecs.push_back(mk(0, 1, 1, 1, 0, 3, 0, 0, 12'h000, 12'h005, 12'h005, 1, 0, 7));
    vecs.push_back(mk(0, 0, 0, 1, 1, 3, 0, 0, 12'h000, 12'h020, 12'h060, 1, 0, 8));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 12'h000, 12'h008, 12'h000, 1, 0, 9));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 12'h000, 12'h009, 12'h009, 0, 1, 10));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 12'h123, 12'h009, 12'h009, 0, 1, 10));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 12'h000, 12'h009, 12'h009, 0, 1, 10));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h009, 12'h009, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h009, 12'h000, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 3, 0, 0, 12'h000, 12'h000, 12'h040, 1, 0, 2));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 12'h000, 12'h040, 12'h040, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h777, 12'h000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 12'h000, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 3, 0, 0, 12'h000, 12'h100, 12'h140, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 7, 0, 0, 12'h000, 12'h001, 12'hFFF, 1, 0, 2));

    @(negedge clk);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pc_next", 32'(pc_next), 32'd0);
    chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      set_in(vecs[i].st, vecs[i].sl, vecs[i].hl, vecs[i].br, vecs[i].rel,
             vecs[i].idx, vecs[i].we, vecs[i].wa, vecs[i].wd);
      step(vecs[i].pc, pn);
      chk($sformatf("vec%0d_pn", i), 32'(pn), 32'(vecs[i].e_pn));
      chk($sformatf("vec%0d_run", i), 32'(running), 32'(vecs[i].e_run));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
      chk($sformatf("vec%0d_cnt", i), 32'(cycle_cnt), 32'(vecs[i].e_cnt));
    end

    // Asynchronous reset between edges while running.
    set_in(0, 0, 0, 1, 0, 3, 0, 0, 0);
    pc_cur = 12'h0AA;
    #2;
    reset_n = 1'b0;
    m_reset();
    #1;
    chk("arst_running", 32'(running), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    chk("arst_pc_next", 32'(pc_next), 32'd0);
    start = 1'b1;
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(12'h000, pn);
    set_in(0, 0, 0, 1, 0, 3, 0, 0, 0);
    step(12'h000, pn);
    chk("lut3_cleared", 32'(pn), 32'd0);
    set_in(0, 0, 0, 1, 0, 7, 0, 0, 0);
    step(12'h000, pn);
    chk("lut7_cleared", 32'(pn), 32'd0);

    // Randomized traffic with a PC register frozen by start.
    pc_reg = '0;
    for (int n = 0; n < 600; n++) begin
      set_in(($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 20),
             ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 30),
             1'($urandom), 5'($urandom), ($urandom_range(0, 99) < 40),
             5'($urandom), 12'($urandom));
      step(pc_reg, pn);
      if (!start) pc_reg = pn;
    end

    // Counter saturation over a long stalled run.
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(pc_reg, pn);
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 65540; n++) step(12'h123, pn);
    chk("cnt_saturated", 32'(cycle_cnt), 32'hFFFF);
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(12'h124, pn);
    chk("sat_halt_done", 32'(done), 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(12'h124, pn);
    chk("sat_halt_cnt", 32'(cycle_cnt), 32'hFFFF);
    chk("sat_halt_pn", 32'(pn), 32'h124);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
